// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and types for the instruction-fetch stage
// Constants and types shared by the fetch stage and its IF/ID register.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] PC_STEP           = 32'd4;

   typedef enum logic [1:0] {
      PC_SEL_HOLD     = 2'd0,
      PC_SEL_REDIRECT = 2'd1,
      PC_SEL_BUBBLE   = 2'd2,
      PC_SEL_SEQ      = 2'd3
   } pc_sel_e;

   // Priority order: stall, then redirect, then memory miss, then sequential fetch.
   function automatic pc_sel_e pc_select(input logic if_write,
                                         input logic redirect_req,
                                         input logic imem_ready);
      if (!if_write)
         return PC_SEL_HOLD;
      else if (redirect_req)
         return PC_SEL_REDIRECT;
      else if (!imem_ready)
         return PC_SEL_BUBBLE;
      else
         return PC_SEL_SEQ;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold, flush and reset
// Hold has priority over flush; a flush loads a bubble that still records the PC.
import if_stage_pkg::*;

module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        valid_out
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (!hold) begin
         pc_d = pc_in;
         if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end else begin
            instr_d = instr_in;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         pc_q    <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out = instr_q;
   assign pc_out    = pc_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, next-PC select, IF/ID register
// Redirects are honoured only while IFWrite=1, since ID operands are stale under a stall.
import if_stage_pkg::*;

module if_stage #(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IFWrite,
   input  logic        Branch,
   input  logic        Jump,
   input  logic [31:0] JumpAddr,
   output logic [31:0] IMemAddr,
   input  logic [31:0] IMemData,
   input  logic        IMemReady,
   output logic [31:0] Instruction_id,
   output logic [31:0] PC_id,
   output logic        Valid_id
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus_step;
   logic        redirect;
   logic        flush;
   pc_sel_e     pc_sel;

   assign redirect     = (Branch | Jump) & IFWrite;
   assign pc_sel       = pc_select(IFWrite, redirect, IMemReady);
   assign pc_plus_step = pc_q + PC_STEP;

   always_comb begin
      pc_d = pc_q;
      case (pc_sel)
         PC_SEL_REDIRECT: pc_d = JumpAddr;
         PC_SEL_SEQ:      pc_d = pc_plus_step;
         default:         pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   // Wrong-path fetch and memory miss both turn into a bubble in IF/ID.
   assign flush = (pc_sel == PC_SEL_REDIRECT) || (pc_sel == PC_SEL_BUBBLE);

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk       (clk),
      .reset     (reset),
      .hold      (~IFWrite),
      .flush     (flush),
      .instr_in  (IMemData),
      .pc_in     (pc_q),
      .instr_out (Instruction_id),
      .pc_out    (PC_id),
      .valid_out (Valid_id)
   );

   assign IMemAddr = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
// Model tracks fetch state from the stage's rules; memory word at address a is {a[15:0],16'hBEEF}.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        IFWrite;
   logic        Branch;
   logic        Jump;
   logic [31:0] JumpAddr;
   logic [31:0] IMemAddr;
   logic [31:0] IMemData;
   logic        IMemReady;
   logic [31:0] Instruction_id;
   logic [31:0] PC_id;
   logic        Valid_id;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_instr, m_pcid;
   logic        m_valid;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], 16'hBEEF};
   endfunction

   assign IMemData = mem_word(IMemAddr);

   if_stage dut (
      .clk            (clk),
      .reset          (reset),
      .IFWrite        (IFWrite),
      .Branch         (Branch),
      .Jump           (Jump),
      .JumpAddr       (JumpAddr),
      .IMemAddr       (IMemAddr),
      .IMemData       (IMemData),
      .IMemReady      (IMemReady),
      .Instruction_id (Instruction_id),
      .PC_id          (PC_id),
      .Valid_id       (Valid_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h13; m_pcid = 32'h0; m_valid = 1'b0;
      end else if (!IFWrite) begin
      end else if (Branch || Jump) begin
         m_pcid = m_pc; m_pc = JumpAddr; m_instr = 32'h13; m_valid = 1'b0;
      end else if (!IMemReady) begin
         m_pcid = m_pc; m_instr = 32'h13; m_valid = 1'b0;
      end else begin
         m_instr = mem_word(m_pc); m_pcid = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("IMemAddr", IMemAddr, m_pc);
      chk("Instruction_id", Instruction_id, m_instr);
      chk("PC_id", PC_id, m_pcid);
      chk("Valid_id", {31'b0, Valid_id}, {31'b0, m_valid});
   endtask

   task automatic set_in(input logic r, input logic w, input logic b, input logic j,
                         input logic [31:0] ja, input logic rdy);
      reset = r; IFWrite = w; Branch = b; Jump = j; JumpAddr = ja; IMemReady = rdy;
   endtask

   initial begin
      m_pc = 0; m_instr = 0; m_pcid = 0; m_valid = 0;
      set_in(1, 1, 0, 0, 32'h0, 1);
      step();
      chk("lit_reset_pc", IMemAddr, 32'h0000_0000);
      chk("lit_reset_instr", Instruction_id, 32'h0000_0013);
      chk("lit_reset_valid", {31'b0, Valid_id}, 32'h0);

      // sequential fetch
      set_in(0, 1, 0, 0, 32'h0, 1);
      step();
      chk("lit_first_instr", Instruction_id, 32'h0000_BEEF);
      chk("lit_first_valid", {31'b0, Valid_id}, 32'h1);
      step(); step(); step();
      chk("lit_pc_10", IMemAddr, 32'h0000_0010);
      chk("lit_instr_c", Instruction_id, 32'h000C_BEEF);

      // taken branch at 0x10
      set_in(0, 1, 1, 0, 32'h40, 1);
      step();
      chk("lit_br_pc", IMemAddr, 32'h0000_0040);
      chk("lit_br_bubble", Instruction_id, 32'h0000_0013);
      set_in(0, 1, 0, 0, 32'h0, 1);
      step();
      chk("lit_br_target", Instruction_id, 32'h0040_BEEF);
      chk("lit_br_pcid", PC_id, 32'h0000_0040);

      // stall at 0x08 with Jump asserted
      set_in(1, 1, 0, 0, 32'h0, 1);
      step();
      set_in(0, 1, 0, 0, 32'h0, 1);
      step(); step();
      set_in(0, 0, 0, 1, 32'h200, 1);
      step(); step();
      chk("lit_stall_pc", IMemAddr, 32'h0000_0008);
      chk("lit_stall_instr", Instruction_id, 32'h0004_BEEF);
      set_in(0, 1, 0, 0, 32'h0, 1);
      step();
      chk("lit_stall_release", Instruction_id, 32'h0008_BEEF);

      // run to 0x20 then miss for three cycles
      for (int i = 0; i < 20 && m_pc != 32'h20; i++) step();
      chk("reach_pc_20", m_pc, 32'h20);
      set_in(0, 1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 3; i++) step();
      chk("lit_miss_pc", IMemAddr, 32'h0000_0020);
      set_in(0, 1, 0, 0, 32'h0, 1);
      step();
      chk("lit_miss_instr", Instruction_id, 32'h0020_BEEF);
      chk("lit_miss_pcid", PC_id, 32'h0000_0020);

      // redirect during miss
      set_in(0, 1, 0, 1, 32'h100, 0);
      step();
      chk("lit_jmiss_pc", IMemAddr, 32'h0000_0100);
      set_in(0, 1, 0, 0, 32'h0, 1);
      step();

      // simultaneous branch and jump, then wrap-around
      set_in(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
      step();
      set_in(0, 1, 0, 0, 32'h0, 1);
      step();
      chk("lit_wrap_pc", IMemAddr, 32'h0000_0000);
      chk("lit_wrap_instr", Instruction_id, 32'hFFFC_BEEF);

      // reset during stall
      step();
      set_in(0, 0, 0, 0, 32'h0, 1);
      step();
      set_in(1, 0, 0, 0, 32'h0, 0);
      step();
      chk("lit_rst_stall_valid", {31'b0, Valid_id}, 32'h0);
      chk("lit_rst_stall_pc", IMemAddr, 32'h0000_0000);

      // pseudo-random mix
      for (int i = 0; i < 200; i++) begin
         set_in(($urandom_range(0, 30) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                {$urandom_range(0, 16'hFFFF), 2'b00}, ($urandom_range(0, 4) != 0));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
